// File: rtl/dataflow_handshake_profiler_if.sv
// Handshake bundle for dataflow_handshake_profiler: ap_ctrl signals of every
// monitored channel, the end-of-run strobe and the registered read port.
// The master side drives the handshakes and reads results; the profiler is the slave.
interface dataflow_handshake_profiler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              finish;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              frozen;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, frozen
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, frozen
  );
endinterface

// File: rtl/dataflow_handshake_profiler.sv
// dataflow_handshake_profiler: per-channel ap_ctrl handshake statistics
// (transaction count, last/min/max start->done latency, busy cycles, sticky
// saturation flag) with a registered read port. All counters saturate.
// Optional feature: define DFMON_INTERVAL_EN to also keep min/max ap_ready
// interval (II) per channel; otherwise ap_ready is ignored and sel 5/6 read 0.
module dataflow_handshake_profiler #(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  dataflow_handshake_profiler_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t state_q [NUM_CH];
  state_t state_d [NUM_CH];
  cnt_t   lat_q   [NUM_CH], lat_d   [NUM_CH];
  cnt_t   txn_q   [NUM_CH], txn_d   [NUM_CH];
  cnt_t   last_q  [NUM_CH], last_d  [NUM_CH];
  cnt_t   min_q   [NUM_CH], min_d   [NUM_CH];
  cnt_t   max_q   [NUM_CH], max_d   [NUM_CH];
  cnt_t   busy_q  [NUM_CH], busy_d  [NUM_CH];
  logic   sat_q   [NUM_CH], sat_d   [NUM_CH];
`ifdef DFMON_INTERVAL_EN
  logic   armed_q [NUM_CH], armed_d [NUM_CH];
  cnt_t   ivl_q   [NUM_CH], ivl_d   [NUM_CH];
  cnt_t   imin_q  [NUM_CH], imin_d  [NUM_CH];
  cnt_t   imax_q  [NUM_CH], imax_d  [NUM_CH];
`else
  logic   unused_ready;
  assign unused_ready = ^bus.ap_ready;
`endif
  logic   frozen_q;
  logic   rd_valid_q;
  cnt_t   rd_data_q;
  cnt_t   rd_mux;

  // Next-state logic for every channel's FSM and statistics; finish gates all updates.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin : next_state
    logic complete;
    logic record;
    cnt_t rec_lat;
    complete = 1'b0;
    record   = 1'b0;
    rec_lat  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      lat_d[ch]   = lat_q[ch];
      txn_d[ch]   = txn_q[ch];
      last_d[ch]  = last_q[ch];
      min_d[ch]   = min_q[ch];
      max_d[ch]   = max_q[ch];
      busy_d[ch]  = busy_q[ch];
      sat_d[ch]   = sat_q[ch];
`ifdef DFMON_INTERVAL_EN
      armed_d[ch] = armed_q[ch];
      ivl_d[ch]   = ivl_q[ch];
      imin_d[ch]  = imin_q[ch];
      imax_d[ch]  = imax_q[ch];
`endif
      complete = bus.ap_done[ch] & bus.ap_continue[ch];
      record   = 1'b0;
      rec_lat  = '0;
      if (!(frozen_q || bus.finish)) begin
        case (state_q[ch])
          IDLE: begin
            if (bus.ap_start[ch]) begin
              if (complete) begin
                record = 1'b1;
              end else begin
                state_d[ch] = BUSY;
                lat_d[ch]   = cnt_t'(1);
              end
            end
          end
          BUSY: begin
            busy_d[ch] = sat_inc(busy_q[ch]);
            if (busy_q[ch] == CNT_MAX) sat_d[ch] = 1'b1;
            if (complete) begin
              record  = 1'b1;
              rec_lat = lat_q[ch];
              if (bus.ap_start[ch]) lat_d[ch] = cnt_t'(1);
              else                  state_d[ch] = IDLE;
            end else begin
              lat_d[ch] = sat_inc(lat_q[ch]);
              if (lat_q[ch] == CNT_MAX) sat_d[ch] = 1'b1;
            end
          end
          default: state_d[ch] = IDLE;
        endcase
        if (record) begin
          txn_d[ch]  = sat_inc(txn_q[ch]);
          if (txn_q[ch] == CNT_MAX) sat_d[ch] = 1'b1;
          last_d[ch] = rec_lat;
          if (rec_lat < min_q[ch]) min_d[ch] = rec_lat;
          if (rec_lat > max_q[ch]) max_d[ch] = rec_lat;
        end
`ifdef DFMON_INTERVAL_EN
        if (bus.ap_ready[ch]) begin
          if (armed_q[ch]) begin
            if (ivl_q[ch] < imin_q[ch]) imin_d[ch] = ivl_q[ch];
            if (ivl_q[ch] > imax_q[ch]) imax_d[ch] = ivl_q[ch];
          end
          armed_d[ch] = 1'b1;
          ivl_d[ch]   = cnt_t'(1);
        end else if (armed_q[ch]) begin
          ivl_d[ch] = sat_inc(ivl_q[ch]);
          if (ivl_q[ch] == CNT_MAX) sat_d[ch] = 1'b1;
        end
`endif
      end
    end
  end

  // Read multiplexer; out-of-range channels read as zero.
  always_comb begin
    rd_mux = '0;
    if (int'(bus.rd_ch) < NUM_CH) begin
      case (bus.rd_sel)
        3'd0: rd_mux = txn_q[bus.rd_ch];
        3'd1: rd_mux = last_q[bus.rd_ch];
        3'd2: rd_mux = min_q[bus.rd_ch];
        3'd3: rd_mux = max_q[bus.rd_ch];
        3'd4: rd_mux = busy_q[bus.rd_ch];
`ifdef DFMON_INTERVAL_EN
        3'd5: rd_mux = imin_q[bus.rd_ch];
        3'd6: rd_mux = imax_q[bus.rd_ch];
`endif
        3'd7: rd_mux = {{(CNT_W-2){1'b0}}, sat_q[bus.rd_ch], state_q[bus.rd_ch] == BUSY};
        default: rd_mux = '0;
      endcase
    end
  end

  // State and statistic registers, frozen flag and registered read port.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= IDLE;
        lat_q[ch]   <= '0;
        txn_q[ch]   <= '0;
        last_q[ch]  <= '0;
        min_q[ch]   <= CNT_MAX;
        max_q[ch]   <= '0;
        busy_q[ch]  <= '0;
        sat_q[ch]   <= 1'b0;
`ifdef DFMON_INTERVAL_EN
        armed_q[ch] <= 1'b0;
        ivl_q[ch]   <= '0;
        imin_q[ch]  <= CNT_MAX;
        imax_q[ch]  <= '0;
`endif
      end
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      txn_q      <= txn_d;
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      sat_q      <= sat_d;
`ifdef DFMON_INTERVAL_EN
      armed_q    <= armed_d;
      ivl_q      <= ivl_d;
      imin_q     <= imin_d;
      imax_q     <= imax_d;
`endif
      frozen_q   <= frozen_q | bus.finish;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.frozen   = frozen_q;

endmodule
